// File: rtl/memory_ctrl.sv
// memory_ctrl
//   Single-port memory of 2**ADDR_W words x DATA_W bits. Requests come in on a
//   valid/ready channel and are served one at a time through an IDLE/WAIT/ACCESS
//   state machine. WAIT_CYCLES wait states emulate slow storage. Each request
//   produces a one-cycle response pulse: read data or a write acknowledge.
//   Optional write protection of addresses 0..PROT_TOP-1 is enabled by defining
//   MEMORY_CTRL_WP_EN. Protected writes are dropped and answered with rsp_err=1.
//
// Parameters: DATA_W (1..64), ADDR_W, WAIT_CYCLES (0..15), PROT_TOP
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  accepting requests (IDLE only)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle response pulse
//   rsp_write  out  op type of the current response
//   rsp_rdata  out  read data; holds the last read value
//   rsp_err    out  error flag, qualified by rsp_valid
//   busy       out  high in WAIT and ACCESS
module memory_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int PROT_TOP    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  if (DATA_W < 1 || DATA_W > 64 || ADDR_W < 1 || ADDR_W > 30 ||
      WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || PROT_TOP < 0 || PROT_TOP > DEPTH) begin : g_bad_params
    $error("memory_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_done;
  logic              w_prot;
  logic              w_mem_we;

`ifdef MEMORY_CTRL_WP_EN
  assign w_prot = (32'(r_addr) < 32'(PROT_TOP));
`else
  assign w_prot = 1'b0;
`endif

  assign w_mem_we = w_done & r_write & ~w_prot;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    req_ready   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter is loaded on acceptance, so WAIT lasts exactly WAIT_CYCLES cycles.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      r_wait_cnt <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;
    end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_done;
      r_rsp_err   <= w_done & r_write & w_prot;
      if (w_done) r_rsp_write <= r_write;
      if (w_done && !r_write) r_rsp_rdata <= r_mem[r_addr];
    end
  end

  // Storage is not reset; an async reset forces IDLE so a pending write never lands.
  always_ff @(posedge CLK) begin
    if (w_mem_we) r_mem[r_addr] <= r_wdata;
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
